// File: rtl/multi_tick_gen_pkg.sv
// Shared timing constants and helpers for the tick generator and the display scan block.
package multi_tick_gen_pkg;

  localparam int TICK_DEF_DIV = 67108864;

  // Width of a channel index, never less than one bit.
  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider slice: count/div/tick/wave, with a divisor applied only at a wrap or while idle.
// Latency: tick and wave are registered one edge after count==div-1; no backpressure.
module tick_channel #(
  parameter int CW      = 27,
  parameter int DEF_DIV = multi_tick_gen_pkg::TICK_DEF_DIV
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          apply_req,
  input  logic [CW-1:0] apply_div,
  output logic          wrap,
  output logic          idle,
  output logic          tick,
  output logic          wave
);

  logic [CW-1:0] count;
  logic [CW-1:0] div;

  assign idle = (div == '0);
  assign wrap = en && !idle && (count == div - CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      div   <= CW'(DEF_DIV);
      tick  <= 1'b0;
      wave  <= 1'b0;
    end else begin
      if (idle) begin
        count <= '0;
        tick  <= 1'b0;
        wave  <= 1'b0;
      end else if (!en) begin
        tick  <= 1'b0;
      end else if (wrap) begin
        count <= '0;
        tick  <= 1'b1;
        wave  <= ~wave;
      end else begin
        count <= count + CW'(1);
        tick  <= 1'b0;
      end
      // The apply always lands where count restarts at 0, so count stays below the new div.
      if (apply_req) begin
        div <= apply_div;
      end
    end
  end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel clock-enable generator with glitch-free run-time divisor reload.
// Latency: ticks registered; backpressure: load_ready low while one load waits for its channel's wrap.
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int CH      = 4,
  parameter int CW      = 27,
  parameter int DEF_DIV = TICK_DEF_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load_valid,
  input  logic [ch_idx_w(CH)-1:0]   load_ch,
  input  logic [CW-1:0]             load_div,
  output logic                      load_ready,
  output logic [CH-1:0]             tick,
  output logic [CH-1:0]             wave
);

  localparam int IW = ch_idx_w(CH);

  logic          pend_valid;
  logic [IW-1:0] pend_ch;
  logic [CW-1:0] pend_div;
  logic [CH-1:0] wrap;
  logic [CH-1:0] idle;
  logic [CH-1:0] apply_req;

  assign load_ready = ~pend_valid;

  // An idle channel has no wrap to wait for, so it takes the divisor on the next edge.
  always_comb begin
    apply_req = '0;
    for (int i = 0; i < CH; i++) begin
      apply_req[i] = pend_valid && (pend_ch == IW'(i)) && (wrap[i] || idle[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else if (|apply_req) begin
      pend_valid <= 1'b0;
    end else if (load_valid && load_ready && (int'(load_ch) < CH)) begin
      pend_valid <= 1'b1;
      pend_ch    <= load_ch;
      pend_div   <= load_div;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    tick_channel #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .apply_req (apply_req[i]),
      .apply_div (pend_div),
      .wrap      (wrap[i]),
      .idle      (idle[i]),
      .tick      (tick[i]),
      .wave      (wave[i])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Randomized bench for multi_tick_gen against a cycle-level behavioural model.
module tb_multi_tick_gen;

  localparam int CH      = 3;
  localparam int CW      = 4;
  localparam int DEF_DIV = 3;
  localparam int IW      = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_ch = '0;
  logic [CW-1:0] load_div = '0;
  logic          load_ready;
  logic [CH-1:0] tick;
  logic [CH-1:0] wave;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_count[CH];
  int m_div[CH];
  bit m_tick[CH];
  bit m_wave[CH];
  bit m_pv;
  int m_pch;
  int m_pdiv;

  multi_tick_gen #(
    .CH      (CH),
    .CW      (CW),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
    .load_ready (load_ready),
    .tick       (tick),
    .wave       (wave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_count[i] = 0;
      m_div[i]   = DEF_DIV;
      m_tick[i]  = 1'b0;
      m_wave[i]  = 1'b0;
    end
    m_pv   = 1'b0;
    m_pch  = 0;
    m_pdiv = 0;
  endfunction

  // One rising edge, using the inputs present at that edge.
  function automatic void model_step();
    bit applied = 1'b0;
    bit accept  = load_valid && !m_pv;
    for (int i = 0; i < CH; i++) begin
      bit wraps = en && (m_div[i] != 0) && (m_count[i] == m_div[i] - 1);
      bit take  = m_pv && (m_pch == i) && (wraps || m_div[i] == 0);
      if (m_div[i] == 0) begin
        m_count[i] = 0;
        m_tick[i]  = 1'b0;
        m_wave[i]  = 1'b0;
      end else if (!en) begin
        m_tick[i]  = 1'b0;
      end else if (wraps) begin
        m_count[i] = 0;
        m_tick[i]  = 1'b1;
        m_wave[i]  = !m_wave[i];
      end else begin
        m_count[i] = m_count[i] + 1;
        m_tick[i]  = 1'b0;
      end
      if (take) begin
        m_div[i] = m_pdiv;
        applied  = 1'b1;
      end
    end
    if (applied) begin
      m_pv = 1'b0;
    end else if (accept && int'(load_ch) < CH) begin
      m_pv   = 1'b1;
      m_pch  = int'(load_ch);
      m_pdiv = int'(load_div);
    end
  endfunction

  function automatic logic [CH-1:0] pack_bits(input bit b[CH]);
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic compare_all();
    check("tick", 32'(tick), 32'(pack_bits(m_tick)));
    check("wave", 32'(wave), 32'(pack_bits(m_wave)));
    check("load_ready", 32'(load_ready), 32'(!m_pv));
  endtask

  task automatic drive_random();
    en         = ($urandom_range(0, 99) < 85);
    load_valid = ($urandom_range(0, 99) < 25);
    load_ch    = IW'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0:       load_div = '0;
      1:       load_div = CW'(15);
      default: load_div = CW'($urandom_range(1, 6));
    endcase
  endtask

  task automatic do_reset();
    drive_random();
    rst = 1'b0;
    #2;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_wave", 32'(wave), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    int first_tick;
    first_tick = -1;
    #12;
    check("por_tick", 32'(tick), 32'd0);
    check("por_wave", 32'(wave), 32'd0);
    check("por_ready", 32'(load_ready), 32'd1);
    model_reset();
    en  = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (c < 12 && first_tick < 0 && tick[0] === 1'b1) first_tick = c + 1;
      if (c < 12) begin
        // Quiet start so the first tick position after reset is observable.
        en         = 1'b1;
        load_valid = 1'b0;
      end else if (c % 700 == 350) begin
        do_reset();
      end else begin
        drive_random();
      end
    end
    check("first_tick_edge", 32'(first_tick), 32'(DEF_DIV));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
